// File: rtl/map_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : map_ram_arbiter_if
// Description : Bundle of the draw read port, the two game-logic write ports,
//               the clear-sweep handshake and the single-port map RAM port.
//               The arbiter uses the slave modport. The surrounding logic
//               (draw, game logic, RAM) uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface map_ram_arbiter_if #(
    parameter int MAP_W  = 32,
    parameter int MAP_H  = 24,
    parameter int TILE_B = 3
) ();
    localparam int c_XB     = $clog2(MAP_W);
    localparam int c_YB     = $clog2(MAP_H);
    localparam int c_ADDR_B = $clog2(MAP_W * MAP_H);

    // draw read port
    logic                         vblank;
    logic                         rd_en;
    logic [c_XB-1:0]              rd_x;
    logic [c_YB-1:0]              rd_y;
    logic [TILE_B-1:0]            rd_data;
    logic                         rd_valid;

    // game-logic write ports, one entry per writer
    logic [1:0]                   wr_req;
    logic [1:0][c_XB-1:0]         wr_x;
    logic [1:0][c_YB-1:0]         wr_y;
    logic [1:0][TILE_B-1:0]       wr_tile;
    logic [1:0]                   wr_gnt;

    // clear sweep
    logic                         clr_req;
    logic                         clr_busy;
    logic                         clr_done;

    // map RAM port
    logic                         ram_en;
    logic                         ram_we;
    logic [c_ADDR_B-1:0]          ram_addr;
    logic [TILE_B-1:0]            ram_wdata;
    logic [TILE_B-1:0]            ram_rdata;

    modport slave (
        input  vblank, rd_en, rd_x, rd_y,
        input  wr_req, wr_x, wr_y, wr_tile,
        input  clr_req, ram_rdata,
        output rd_data, rd_valid, wr_gnt, clr_busy, clr_done,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output vblank, rd_en, rd_x, rd_y,
        output wr_req, wr_x, wr_y, wr_tile,
        output clr_req, ram_rdata,
        input  rd_data, rd_valid, wr_gnt, clr_busy, clr_done,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/map_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : map_ram_arbiter
// Description : Owns the single-port map tile RAM. Draw reads have absolute
//               priority with a fixed latency of two cycles. Two writers are
//               served round-robin in write slots. A clear sweep fills the map
//               with the EMPTY tile code.
// Revision    : 1.0 - initial release
// ============================================================================
module map_ram_arbiter #(
    parameter int MAP_W        = 32,
    parameter int MAP_H        = 24,
    parameter int TILE_B       = 3,
    parameter int EMPTY_CODE   = 0,
    parameter int WR_IN_ACTIVE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    map_ram_arbiter_if.slave   bus
);
    localparam int c_XB     = $clog2(MAP_W);
    localparam int c_YB     = $clog2(MAP_H);
    localparam int c_ADDR_B = $clog2(MAP_W * MAP_H);

    localparam logic [c_ADDR_B-1:0] c_LAST   = c_ADDR_B'(MAP_W * MAP_H - 1);
    localparam logic [c_ADDR_B-1:0] c_MAP_WA = c_ADDR_B'(MAP_W);
    localparam logic [TILE_B-1:0]   c_EMPTY  = TILE_B'(EMPTY_CODE);
    localparam logic                c_WR_ACT = (WR_IN_ACTIVE != 0);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_ptr;        // preferred writer for the next grant
    logic [c_ADDR_B-1:0]  r_clr_cnt;
    logic                 r_clr_busy;
    logic                 r_clr_done;
    logic                 r_ram_en;
    logic                 r_ram_we;
    logic [c_ADDR_B-1:0]  r_ram_addr;
    logic [TILE_B-1:0]    r_ram_wdata;
    logic                 r_rd_valid;

    logic                 w_slot;
    logic                 w_wr_ok;
    logic [1:0]           w_gnt;
    logic                 w_gnt_idx;
    logic [c_ADDR_B-1:0]  w_rd_addr;
    logic [c_ADDR_B-1:0]  w_wr_addr;

    // A write may use the RAM only when the draw pipeline is not reading
    // and the raster is in vblank (or active-video writes are enabled).
    assign w_slot  = !bus.rd_en && (bus.vblank || c_WR_ACT);

    // Grants are gated by reset and by a clear request arriving this cycle.
    assign w_wr_ok = rst_n && (r_state == S_IDLE) && w_slot && !bus.clr_req;

    // Round-robin pick: the preferred writer first, otherwise the other one.
    always_comb begin
        w_gnt = 2'b00;
        if (w_wr_ok) begin
            if (bus.wr_req[r_ptr]) begin
                w_gnt[r_ptr] = 1'b1;
            end else if (bus.wr_req[~r_ptr]) begin
                w_gnt[~r_ptr] = 1'b1;
            end
        end
    end

    assign w_gnt_idx = w_gnt[1];
    assign w_rd_addr = c_ADDR_B'(bus.rd_y) * c_MAP_WA + c_ADDR_B'(bus.rd_x);
    assign w_wr_addr = c_ADDR_B'(bus.wr_y[w_gnt_idx]) * c_MAP_WA
                     + c_ADDR_B'(bus.wr_x[w_gnt_idx]);

    // Arbitration FSM: registers the winning RAM access and runs the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_clr_cnt   <= '0;
            r_clr_busy  <= 1'b0;
            r_clr_done  <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            // RAM data returns one cycle after a read access was presented.
            r_rd_valid <= r_ram_en && !r_ram_we;

            if (bus.rd_en) begin
                r_ram_en   <= 1'b1;
                r_ram_addr <= w_rd_addr;
            end else if (|w_gnt) begin
                r_ram_en    <= 1'b1;
                r_ram_we    <= 1'b1;
                r_ram_addr  <= w_wr_addr;
                r_ram_wdata <= bus.wr_tile[w_gnt_idx];
                r_ptr       <= ~w_gnt_idx;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        r_state    <= S_CLEAR;
                        r_clr_cnt  <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (w_slot) begin
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_clr_cnt;
                        r_ram_wdata <= c_EMPTY;
                        if (r_clr_cnt == c_LAST) begin
                            r_state    <= S_IDLE;
                            r_clr_busy <= 1'b0;
                            r_clr_done <= 1'b1;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_gnt    = w_gnt;
    assign bus.rd_data   = bus.ram_rdata;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.clr_busy  = r_clr_busy;
    assign bus.clr_done  = r_clr_done;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire
